// File: rtl/vending_pkg.sv
// Shared constants for the vending controller: default coin values,
// default price and a helper that sizes the credit register.
package vending_pkg;

  localparam int DEF_PRICE = 75;
  localparam int DEF_Q_VAL = 25;
  localparam int DEF_D_VAL = 100;

  // Largest credit ever held is price-1 plus the biggest coin,
  // so the register must reach price-1+dval (i.e. < price+dval).
  function automatic int credit_width(input int price,
                                      input int dval);
    return $clog2(price + dval);
  endfunction

  localparam int DEF_CW = credit_width(DEF_PRICE, DEF_D_VAL);

endpackage

// File: rtl/vending_coin_sel.sv
// Coin priority encoder: dollar beats quarter, nothing gives zero.
// Ports: Q_in, D_in (coin strobes) -> add [CW-1:0] cents to credit.
module vending_coin_sel
  import vending_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int Q_VAL = DEF_Q_VAL,
  parameter int D_VAL = DEF_D_VAL
) (
  input  logic          Q_in,
  input  logic          D_in,
  output logic [CW-1:0] add
);

  // Both strobes may be high at once, so this is an
  // ordered decode rather than a one-hot one.
  always_comb begin
    add = '0;
    if (D_in)
      add = CW'(D_VAL);
    else if (Q_in)
      add = CW'(Q_VAL);
  end

endmodule

// File: rtl/vending.sv
// Vending controller: accumulates coin credit, pulses dispense at PRICE,
// pulses change on overpay. Ports: clk, rstn, Q_in, D_in -> dispense,
// change (+ change_amt [CW-1:0] when VENDING_CHANGE_AMT_EN is defined).
module vending
  import vending_pkg::*;
#(
  parameter int PRICE = DEF_PRICE,
  parameter int Q_VAL = DEF_Q_VAL,
  parameter int D_VAL = DEF_D_VAL,
  parameter int CW    = credit_width(PRICE, D_VAL)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          Q_in,
  input  logic          D_in,
`ifdef VENDING_CHANGE_AMT_EN
  output logic [CW-1:0] change_amt,
`endif
  output logic          dispense,
  output logic          change
);

  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);

  logic [CW-1:0] credit;
  logic [CW-1:0] credit_nx;
  logic [CW-1:0] add;
  logic [CW:0]   sum;
  logic          hit;
  logic          over;
  logic          dispense_nx;
  logic          change_nx;

  vending_coin_sel #(
    .CW    (CW),
    .Q_VAL (Q_VAL),
    .D_VAL (D_VAL)
  ) u_coin_sel (
    .Q_in (Q_in),
    .D_in (D_in),
    .add  (add)
  );

  // One extra bit so credit + dollar never wraps.
  assign sum  = {1'b0, credit} + {1'b0, add};
  assign hit  = (sum >= PRICE_W);
  assign over = (sum > PRICE_W);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit   <= '0;
      dispense <= 1'b0;
      change   <= 1'b0;
    end else begin
      credit   <= credit_nx;
      dispense <= dispense_nx;
      change   <= change_nx;
    end
  end

  // A completed purchase always empties the credit; any
  // excess leaves through change, never carried forward.
  always_comb begin
    credit_nx = sum[CW-1:0];
    if (hit)
      credit_nx = '0;
  end

  always_comb begin
    dispense_nx = hit;
    change_nx   = over;
  end

`ifdef VENDING_CHANGE_AMT_EN
  logic [CW-1:0] amt_nx;

  always_comb begin
    amt_nx = '0;
    if (over)
      amt_nx = CW'(sum - PRICE_W);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      change_amt <= '0;
    else
      change_amt <= amt_nx;
  end
`endif

endmodule

// File: tb/tb_vending.sv
// Self-checking bench for vending: directed scenarios plus
// randomized coin streams against a cents-level reference model.
module tb_vending;

  logic       clk;
  logic       rstn;
  logic       Q_in;
  logic       D_in;
  logic       dispense;
  logic       change;
`ifdef VENDING_CHANGE_AMT_EN
  logic [7:0] change_amt;
`endif

  int n_chk;
  int n_err;

  // reference model state, in cents
  int m_credit;
  bit m_disp;
  bit m_chg;
  int m_amt;

  vending dut (
    .clk      (clk),
    .rstn     (rstn),
    .Q_in     (Q_in),
    .D_in     (D_in),
`ifdef VENDING_CHANGE_AMT_EN
    .change_amt (change_amt),
`endif
    .dispense (dispense),
    .change   (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present coins, take one edge, advance the model, land 1ns past the edge.
  task automatic cyc(input bit q, input bit d);
    int add;
    int sum;
    Q_in = q;
    D_in = d;
    @(posedge clk);
    add = d ? 100 : (q ? 25 : 0);
    sum = m_credit + add;
    if (sum >= 75) begin
      m_disp   = 1;
      m_chg    = (sum > 75);
      m_amt    = m_chg ? sum - 75 : 0;
      m_credit = 0;
    end else begin
      m_disp   = 0;
      m_chg    = 0;
      m_amt    = 0;
      m_credit = sum;
    end
    #1;
  endtask

  task automatic do_reset();
    Q_in = 0;
    D_in = 0;
    rstn = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    m_credit = 0;
    m_disp = 0;
    m_chg = 0;
    m_amt = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    for (int i = 0; i < 6; i++) begin
      Q_in = 1'($urandom);
      D_in = 1'($urandom);
      @(posedge clk);
      #1;
      n_chk++;
      if (dispense !== 1'b0 || change !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: dispense=%b change=%b need 0 0",
                 dispense, change);
      end
    end
    @(negedge clk);
    rstn = 1;
    m_credit = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      n_chk++;
      if (dispense !== (i == 2) || change !== 1'b0) begin
        n_err++;
        $display("FAIL reset_qqq[%0d]: dispense=%b change=%b need %b 0",
                 i, dispense, change, i == 2);
      end
    end
    cyc(0, 0);
  endtask

  task automatic test_dollar();
    cyc(0, 1);
    n_chk++;
    if (dispense !== 1'b1 || change !== 1'b1) begin
      n_err++;
      $display("FAIL dollar: dispense=%b change=%b need 1 1",
               dispense, change);
    end
`ifdef VENDING_CHANGE_AMT_EN
    n_chk++;
    if (change_amt !== 8'd25) begin
      n_err++;
      $display("FAIL dollar_amt: got %0d need 25", change_amt);
    end
`endif
    cyc(0, 0);
    n_chk++;
    if (dispense !== 1'b0 || change !== 1'b0) begin
      n_err++;
      $display("FAIL dollar_after: dispense=%b change=%b need 0 0",
               dispense, change);
    end
  endtask

  task automatic test_q_then_d();
    cyc(1, 0);
    n_chk++;
    if (dispense !== 1'b0) begin
      n_err++;
      $display("FAIL qd_first: dispense=%b need 0", dispense);
    end
    cyc(0, 1);
    n_chk++;
    if (dispense !== 1'b1 || change !== 1'b1) begin
      n_err++;
      $display("FAIL qd: dispense=%b change=%b need 1 1",
               dispense, change);
    end
`ifdef VENDING_CHANGE_AMT_EN
    n_chk++;
    if (change_amt !== 8'd50) begin
      n_err++;
      $display("FAIL qd_amt: got %0d need 50", change_amt);
    end
`endif
    cyc(0, 0);
    n_chk++;
    if (dispense !== 1'b0 || change !== 1'b0) begin
      n_err++;
      $display("FAIL qd_after: dispense=%b change=%b need 0 0",
               dispense, change);
    end
  endtask

  task automatic test_both();
    cyc(1, 1);
    n_chk++;
    if (dispense !== 1'b1 || change !== 1'b1) begin
      n_err++;
      $display("FAIL both: dispense=%b change=%b need 1 1",
               dispense, change);
    end
`ifdef VENDING_CHANGE_AMT_EN
    n_chk++;
    if (change_amt !== 8'd25) begin
      n_err++;
      $display("FAIL both_amt: got %0d need 25", change_amt);
    end
`endif
    // quarter was dropped: two more quarters must not complete
    cyc(1, 0);
    cyc(1, 0);
    n_chk++;
    if (dispense !== 1'b0) begin
      n_err++;
      $display("FAIL both_qdrop: dispense=%b need 0", dispense);
    end
    cyc(1, 0);
    n_chk++;
    if (dispense !== 1'b1 || change !== 1'b0) begin
      n_err++;
      $display("FAIL both_q3: dispense=%b change=%b need 1 0",
               dispense, change);
    end
    cyc(0, 0);
  endtask

  task automatic test_async_reset();
    // outputs clear immediately, without waiting for an edge
    cyc(0, 1);
    #2;
    rstn = 0;
    #1;
    n_chk++;
    if (dispense !== 1'b0 || change !== 1'b0) begin
      n_err++;
      $display("FAIL async_clr: dispense=%b change=%b need 0 0",
               dispense, change);
    end
    @(negedge clk);
    rstn = 1;
    m_credit = 0;
    // partial credit discarded mid-purchase
    cyc(1, 0);
    cyc(1, 0);
    @(negedge clk);
    rstn = 0;
    #2;
    rstn = 1;
    m_credit = 0;
    cyc(1, 0);
    n_chk++;
    if (dispense !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_q1: dispense=%b need 0", dispense);
    end
    cyc(1, 0);
    n_chk++;
    if (dispense !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_q2: dispense=%b need 0", dispense);
    end
    cyc(1, 0);
    n_chk++;
    if (dispense !== 1'b1 || change !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_q3: dispense=%b change=%b need 1 0",
               dispense, change);
    end
    cyc(0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1);
      n_chk++;
      if (dispense !== 1'b1 || change !== 1'b1) begin
        n_err++;
        $display("FAIL b2b[%0d]: dispense=%b change=%b need 1 1",
                 i, dispense, change);
      end
    end
    cyc(0, 0);
  endtask

  task automatic test_random();
    int quarters;
    int disp_cnt;
    bit q;
    bit d;
    do_reset();
    quarters = 0;
    disp_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      q = 1'($urandom);
      quarters += int'(q);
      cyc(q, 0);
      disp_cnt += int'(dispense === 1'b1);
      n_chk++;
      if (dispense !== m_disp || change !== 1'b0) begin
        n_err++;
        $display("FAIL rand_q[%0d]: dispense=%b change=%b need %b 0",
                 i, dispense, change, m_disp);
      end
    end
    n_chk++;
    if (disp_cnt != quarters / 3) begin
      n_err++;
      $display("FAIL rand_q_count: got %0d need %0d",
               disp_cnt, quarters / 3);
    end
    do_reset();
    for (int i = 0; i < 100; i++) begin
      d = 1'($urandom);
      cyc(0, d);
      n_chk++;
      if (dispense !== d || change !== d) begin
        n_err++;
        $display("FAIL rand_d[%0d]: dispense=%b change=%b need %b %b",
                 i, dispense, change, d, d);
      end
    end
    // mixed stream against the full model
    for (int i = 0; i < 200; i++) begin
      q = 1'($urandom);
      d = ($urandom_range(0, 3) == 0);
      cyc(q, d);
      n_chk++;
      if (dispense !== m_disp || change !== m_chg) begin
        n_err++;
        $display("FAIL rand_mix[%0d]: dispense=%b change=%b need %b %b",
                 i, dispense, change, m_disp, m_chg);
      end
`ifdef VENDING_CHANGE_AMT_EN
      n_chk++;
      if (int'(change_amt) != m_amt) begin
        n_err++;
        $display("FAIL rand_amt[%0d]: got %0d need %0d",
                 i, change_amt, m_amt);
      end
`endif
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_credit = 0;
    m_disp = 0;
    m_chg = 0;
    m_amt = 0;
    Q_in = 0;
    D_in = 0;
    rstn = 0;
    test_reset();
    test_dollar();
    test_q_then_d();
    test_both();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vending.md
Name: vending

Overview:
- Coin-operated vending controller. Accepts quarter and dollar coin strobes, accumulates credit and pulses `dispense` once credit reaches the item price. Pulses `change` when the credit exceeded the price.
- Standalone leaf block sitting between the coin-acceptor front end and the dispenser/change actuators.
- Credit is tracked internally in cents. Default price is 75 cents.

Parameters:
- PRICE, 75, item price in cents; must satisfy 0 < PRICE <= 2^CW-1.
- Q_VAL, 25, value of one quarter in cents.
- D_VAL, 100, value of one dollar in cents.
- CW, 8, credit register width; must hold PRICE-1+D_VAL.

Ports:
- clk  input  1  rising-edge system clock.
- rstn  input  1  asynchronous active-low reset.
- Q_in  input  1  quarter inserted; each sampled-high cycle counts as one quarter.
- D_in  input  1  dollar inserted; each sampled-high cycle counts as one dollar.
- dispense  output  1  registered one-cycle pulse: release one item.
- change  output  1  registered one-cycle pulse: return excess credit; asserted only together with dispense.

Behaviour:
- Interface (already decided): single clock `clk`; reset `rstn` is asynchronous and active-low.
- Reset (rstn=0, asynchronous, any time including mid-purchase):
  - credit=0, dispense=0, change=0 immediately.
  - Partial credit is discarded.
  - The first sampling edge after rstn deasserts is treated normally.
- Every rising clk edge:
  - add = D_VAL if D_in=1; else Q_VAL if Q_in=1; else 0.
  - sum = credit + add, computed CW+1 bits wide (no overflow).
- Simultaneous Q_in=1 and D_in=1: dollar has priority; the quarter is ignored (not credited, not refunded).
- If sum >= PRICE:
  - dispense<=1 and credit<=0.
  - change<=1 if sum > PRICE, else 0.
  - Only one item is dispensed per cycle; excess is returned via change, never carried over.
- Else: credit<=sum, dispense<=0, change<=0.
- Latency:
  - Outputs are registered and become visible right after the clock edge that sampled the completing coin.
  - Pulse width is exactly one cycle unless the next cycle also completes a purchase. Back-to-back dollars give dispense high on consecutive cycles.
- Default-parameter state view (implemented as credit counter; states map to credit values):
  - IDLE(0): Q→C25; D→dispense+change→IDLE.
  - C25: Q→C50; D→dispense+change→IDLE.
  - C50: Q→dispense, no change→IDLE; D→dispense+change→IDLE.
  - No coin: hold state, outputs 0.
- No coin input: credit held indefinitely (no timeout).

Optional Feature:
- Macro VENDING_CHANGE_AMT_EN.
- Defined: adds output port `change_amt` [CW-1:0], registered, equal to sum-PRICE in the cycle change=1, else 0. Reset value 0.
- Undefined: port absent; change is a bare strobe and the amount is implied by the actuator.
- dispense/change timing is identical in both builds.

Decomposition:
- Shared package `vending_pkg`: default coin values, default price, and a credit-width helper constant/function.
- Single-module implementation: credit register plus compare/subtract logic.
- Optional sub-module `vending_coin_sel`: combinational priority encoder producing add from Q_in/D_in.

Test Plan:
- Reset: hold rstn=0 with coins toggling → dispense=0, change=0, credit=0; release, then Q,Q,Q → dispense pulses after third quarter, change=0.
- D_in single cycle from idle → dispense=1 and change=1 for exactly one cycle; credit returns to 0 (change_amt=25 if VENDING_CHANGE_AMT_EN).
- Q then D (credit 25+100=125) → dispense=1, change=1 (change_amt=50); next cycle both 0.
- Q and D high together from idle → treated as dollar: dispense=1, change=1 (change_amt=25), quarter not counted.
- Q,Q then rstn pulse low mid-cycle, then Q → no dispense (credit restarted at 25).
- Random Q_in for 100 cycles, then reset, then random D_in for 100 cycles → scoreboard: dispense count = floor(quarters/3) in phase 1; dispense=change=D_in delayed one cycle in phase 2.
